mem_bus_arbiter: RTL and testbench

- Arbitrates one shared memory port (unified L1 cache side) between the instruction-fetch requester and the load/store requester of the riscv_32i core.
- Sits between the imem/dmem front ends and the cache bus.
- Serialises transactions and returns data with a per-requester wait handshake.
- Includes a watchdog that flags a hung memory port.

---
 rtl/mem_arb_pkg.sv | 9 +
 rtl/mem_arb_watchdog.sv | 40 ++++
 rtl/mem_bus_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory bus arbiter.
package mem_arb_pkg;

   typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
   typedef enum logic {OWN_I, OWN_D} arb_owner_t;

   localparam int WDOG_W = 16;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Hung-port watchdog: counts BUSY cycles without ack, sticky error on TIMEOUT.
module mem_arb_watchdog
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic busy,
   input  logic ack,
   output logic err
);

   localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TIMEOUT);

   logic [WDOG_W-1:0] count;
   logic              err_q;
   logic              hit;

   assign hit = busy & (count == LIMIT);
   assign err = err_q | hit;

   // Counter sits at zero while idle, so every BUSY entry starts fresh.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
         err_q <= 1'b0;
      end else begin
         if (!busy) begin
            count <= '0;
         end else if (!ack && count != LIMIT) begin
            count <= count + 1'b1;
         end
         if (hit) begin
            err_q <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between fetch and load/store requesters.
// Define MEM_ARB_RR_EN for round-robin instead of fixed D-over-I priority.
module mem_bus_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_wait,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [3:0]        d_mask,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_wait,
   output logic              m_req,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   output logic [3:0]        m_mask,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic              m_ack,
   output logic              bus_err
);

   arb_state_t state, next_state;
   arb_owner_t owner, next_owner;
   arb_owner_t winner;
   logic       busy;
   logic       done;

   assign busy = (state == ARB_BUSY);
   assign done = busy & m_ack;

`ifdef MEM_ARB_RR_EN
   arb_owner_t last_own;

   // On a tie, serve whoever did not complete the previous transaction.
   always_comb begin
      winner = d_req ? OWN_D : OWN_I;
      if (i_req && d_req) begin
         winner = (last_own == OWN_D) ? OWN_I : OWN_D;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_own <= OWN_D;
      end else if (done) begin
         last_own <= owner;
      end
   end
`else
   always_comb begin
      winner = d_req ? OWN_D : OWN_I;
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ARB_IDLE;
         owner <= OWN_D;
      end else begin
         state <= next_state;
         owner <= next_owner;
      end
   end

   always_comb begin
      next_state = state;
      next_owner = owner;
      unique case (state)
         ARB_IDLE: begin
            if (i_req || d_req) begin
               next_state = ARB_BUSY;
               next_owner = winner;
            end
         end
         ARB_BUSY: begin
            if (m_ack) begin
               next_state = ARB_IDLE;
            end
         end
      endcase
   end

   always_comb begin
      m_req   = 1'b0;
      m_we    = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      m_mask  = 4'b0000;
      if (busy) begin
         m_req = 1'b1;
         if (owner == OWN_D) begin
            m_we    = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
            m_mask  = d_mask;
         end else begin
            m_addr = i_addr;
         end
      end
   end

   assign i_wait = i_req & ~(done & (owner == OWN_I));
   assign d_wait = d_req & ~(done & (owner == OWN_D));

   // Read data is held at zero while reset is applied.
   assign i_rdata = reset ? '0 : m_rdata;
   assign d_rdata = reset ? '0 : m_rdata;

   mem_arb_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk   (clk),
      .reset (reset),
      .busy  (busy),
      .ack   (m_ack),
      .err   (bus_err)
   );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (watchdog TIMEOUT=4).
module tb_mem_bus_arbiter;

`ifdef MEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req;
   logic [31:0] i_addr;
   logic [31:0] i_rdata;
   logic        i_wait;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_mask;
   logic [31:0] d_rdata;
   logic        d_wait;
   logic        m_req;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_mask;
   logic [31:0] m_rdata;
   logic        m_ack;
   logic        bus_err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .TIMEOUT (4)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .i_req   (i_req),
      .i_addr  (i_addr),
      .i_rdata (i_rdata),
      .i_wait  (i_wait),
      .d_req   (d_req),
      .d_we    (d_we),
      .d_addr  (d_addr),
      .d_wdata (d_wdata),
      .d_mask  (d_mask),
      .d_rdata (d_rdata),
      .d_wait  (d_wait),
      .m_req   (m_req),
      .m_we    (m_we),
      .m_addr  (m_addr),
      .m_wdata (m_wdata),
      .m_mask  (m_mask),
      .m_rdata (m_rdata),
      .m_ack   (m_ack),
      .bus_err (bus_err)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      i_req = 1'b0; i_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0;
      d_wdata = '0; d_mask = 4'h0;
      m_rdata = 32'hFFFF_FFFF; m_ack = 1'b0;
      #2;
      total++;
      if (m_req !== 1'b0 || m_addr !== 32'h0 || bus_err !== 1'b0) begin
         bad++;
         $display("FAIL rst_outs m_req=%b m_addr=%h err=%b want 0 0 0",
                  m_req, m_addr, bus_err);
      end
      total++;
      if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
         bad++;
         $display("FAIL rst_rdata i=%h d=%h want 0", i_rdata, d_rdata);
      end
      i_req = 1'b1; d_req = 1'b1;
      #1;
      total++;
      if (i_wait !== 1'b1 || d_wait !== 1'b1 || m_req !== 1'b0) begin
         bad++;
         $display("FAIL rst_wait iw=%b dw=%b mreq=%b want 1 1 0",
                  i_wait, d_wait, m_req);
      end
      i_req = 1'b0; d_req = 1'b0;
      tick;
      reset = 1'b0;
      #1;
      total++;
      if (m_req !== 1'b0 || i_wait !== 1'b0 || d_wait !== 1'b0) begin
         bad++;
         $display("FAIL rst_release mreq=%b iw=%b dw=%b want 0 0 0",
                  m_req, i_wait, d_wait);
      end
   endtask

   task automatic test_single_fetch;
      tick;
      i_req = 1'b1; i_addr = 32'h0000_0040;
      #1;
      total++;
      if (m_req !== 1'b0 || i_wait !== 1'b1) begin
         bad++;
         $display("FAIL fetch_idle mreq=%b iw=%b want 0 1", m_req, i_wait);
      end
      tick; #1;
      total++;
      if (m_req !== 1'b1 || m_addr !== 32'h40 ||
          m_we !== 1'b0 || m_mask !== 4'h0) begin
         bad++;
         $display("FAIL fetch_bus mreq=%b addr=%h we=%b mask=%h want 1 40 0 0",
                  m_req, m_addr, m_we, m_mask);
      end
      total++;
      if (i_wait !== 1'b1) begin
         bad++;
         $display("FAIL fetch_wait1 iw=%b want 1", i_wait);
      end
      tick; tick; #1;
      total++;
      if (i_wait !== 1'b1 || m_req !== 1'b1) begin
         bad++;
         $display("FAIL fetch_wait3 iw=%b mreq=%b want 1 1", i_wait, m_req);
      end
      tick;
      m_ack = 1'b1; m_rdata = 32'h0010_0093;
      #1;
      total++;
      if (i_wait !== 1'b0 || i_rdata !== 32'h0010_0093) begin
         bad++;
         $display("FAIL fetch_ack iw=%b rdata=%h want 0 00100093",
                  i_wait, i_rdata);
      end
      tick;
      m_ack = 1'b0; i_req = 1'b0;
      #1;
      total++;
      if (m_req !== 1'b0) begin
         bad++;
         $display("FAIL fetch_done mreq=%b want 0", m_req);
      end
   endtask

   task automatic test_simultaneous;
      tick;
      i_req = 1'b1; i_addr = 32'h0000_0080;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0100;
      d_wdata = 32'hDEAD_BEEF; d_mask = 4'b0011;
      tick; #1;
      total++;
      if (m_req !== 1'b1 || m_we !== 1'b1 || m_mask !== 4'b0011 ||
          m_addr !== 32'h100 || m_wdata !== 32'hDEAD_BEEF) begin
         bad++;
         $display("FAIL sim_d_bus req=%b we=%b mask=%b addr=%h wd=%h",
                  m_req, m_we, m_mask, m_addr, m_wdata);
      end
      tick;
      m_ack = 1'b1;
      #1;
      total++;
      if (d_wait !== 1'b0 || i_wait !== 1'b1) begin
         bad++;
         $display("FAIL sim_d_ack dw=%b iw=%b want 0 1", d_wait, i_wait);
      end
      tick;
      m_ack = 1'b0; d_req = 1'b0; d_we = 1'b0;
      #1;
      total++;
      if (m_req !== 1'b0 || i_wait !== 1'b1) begin
         bad++;
         $display("FAIL sim_bubble mreq=%b iw=%b want 0 1", m_req, i_wait);
      end
      tick; #1;
      total++;
      if (m_req !== 1'b1 || m_addr !== 32'h80 ||
          m_we !== 1'b0 || m_mask !== 4'h0) begin
         bad++;
         $display("FAIL sim_i_bus req=%b addr=%h we=%b mask=%h want 1 80 0 0",
                  m_req, m_addr, m_we, m_mask);
      end
      tick;
      m_ack = 1'b1;
      #1;
      total++;
      if (i_wait !== 1'b0) begin
         bad++;
         $display("FAIL sim_i_ack iw=%b want 0", i_wait);
      end
      tick;
      m_ack = 1'b0; i_req = 1'b0;
   endtask

   task automatic test_arbitration;
      logic exp_d;
      reset = 1'b1;
      #1;
      reset = 1'b0;
      tick;
      i_req = 1'b1; i_addr = 32'h0000_0500;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0600;
      d_wdata = 32'h0000_0011; d_mask = 4'hF;
      for (int k = 0; k < 4; k++) begin
         exp_d = RR ? k[0] : 1'b1;
         tick;
         m_ack = 1'b1;
         #1;
         total++;
         if (m_addr !== (exp_d ? 32'h600 : 32'h500) || m_we !== exp_d ||
             i_wait !== exp_d || d_wait !== ~exp_d) begin
            bad++;
            $display("FAIL arb_%0d addr=%h we=%b iw=%b dw=%b want_d=%b",
                     k, m_addr, m_we, i_wait, d_wait, exp_d);
         end
         tick;
         m_ack = 1'b0;
         #1;
         total++;
         if (m_req !== 1'b0) begin
            bad++;
            $display("FAIL arb_bubble_%0d mreq=%b want 0", k, m_req);
         end
      end
      i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
   endtask

   task automatic test_owner_drop;
      tick;
      i_req = 1'b1; i_addr = 32'h0000_0200;
      tick;
      i_req = 1'b0;
      #1;
      total++;
      if (m_req !== 1'b1 || i_wait !== 1'b0 || d_wait !== 1'b0) begin
         bad++;
         $display("FAIL drop_busy mreq=%b iw=%b dw=%b want 1 0 0",
                  m_req, i_wait, d_wait);
      end
      tick;
      m_ack = 1'b1;
      #1;
      total++;
      if (i_wait !== 1'b0 || d_wait !== 1'b0) begin
         bad++;
         $display("FAIL drop_ack iw=%b dw=%b want 0 0", i_wait, d_wait);
      end
      tick;
      m_ack = 1'b0;
      #1;
      total++;
      if (m_req !== 1'b0) begin
         bad++;
         $display("FAIL drop_idle mreq=%b want 0", m_req);
      end
      tick; #1;
      total++;
      if (m_req !== 1'b0) begin
         bad++;
         $display("FAIL drop_spurious mreq=%b want 0", m_req);
      end
   endtask

   task automatic test_idle_ack;
      tick;
      m_ack = 1'b1;
      tick;
      m_ack = 1'b0;
      #1;
      total++;
      if (m_req !== 1'b0 || bus_err !== 1'b0) begin
         bad++;
         $display("FAIL idle_ack mreq=%b err=%b want 0 0", m_req, bus_err);
      end
   endtask

   task automatic test_watchdog;
      tick;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300;
      for (int c = 1; c <= 4; c++) begin
         tick; #1;
         total++;
         if (bus_err !== 1'b0 || m_req !== 1'b1) begin
            bad++;
            $display("FAIL wdog_cyc%0d err=%b mreq=%b want 0 1",
                     c, bus_err, m_req);
         end
      end
      tick; #1;
      total++;
      if (bus_err !== 1'b1) begin
         bad++;
         $display("FAIL wdog_cyc5 err=%b want 1", bus_err);
      end
      tick;
      m_ack = 1'b1;
      #1;
      total++;
      if (bus_err !== 1'b1 || d_wait !== 1'b0) begin
         bad++;
         $display("FAIL wdog_ack err=%b dw=%b want 1 0", bus_err, d_wait);
      end
      tick;
      m_ack = 1'b0; d_req = 1'b0;
      #1;
      total++;
      if (bus_err !== 1'b1 || m_req !== 1'b0) begin
         bad++;
         $display("FAIL wdog_sticky err=%b mreq=%b want 1 0", bus_err, m_req);
      end
   endtask

   task automatic test_reset_mid;
      tick;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0340;
      tick; #1;
      total++;
      if (m_req !== 1'b1) begin
         bad++;
         $display("FAIL rmid_busy mreq=%b want 1", m_req);
      end
      reset = 1'b1;
      #1;
      total++;
      if (m_req !== 1'b0 || bus_err !== 1'b0 || d_wait !== 1'b1) begin
         bad++;
         $display("FAIL rmid_async mreq=%b err=%b dw=%b want 0 0 1",
                  m_req, bus_err, d_wait);
      end
      tick;
      reset = 1'b0;
      #1;
      total++;
      if (m_req !== 1'b0) begin
         bad++;
         $display("FAIL rmid_idle mreq=%b want 0", m_req);
      end
      tick; #1;
      total++;
      if (m_req !== 1'b1 || m_addr !== 32'h340) begin
         bad++;
         $display("FAIL rmid_regrant mreq=%b addr=%h want 1 340",
                  m_req, m_addr);
      end
      m_ack = 1'b1;
      #1;
      total++;
      if (d_wait !== 1'b0) begin
         bad++;
         $display("FAIL rmid_ack dw=%b want 0", d_wait);
      end
      tick;
      m_ack = 1'b0; d_req = 1'b0;
   endtask

   initial begin
      test_reset;
      test_single_fetch;
      test_simultaneous;
      test_arbitration;
      test_owner_drop;
      test_idle_ack;
      test_watchdog;
      test_reset_mid;
      tick;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
